// File: rtl/mc_control_unit.sv
// Multicycle control unit: main FSM, ALU decoder, PC-write logic and instruction decoder.
// Latency: outputs are combinational from the current state (plus Op/Funct/Rd); state advances every clk.
// Backpressure: none; multiply holds the FSM in MULEXEC for MUL_CYCLES cycles with Busy high.
module mc_control_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            Instr74,
  output logic                  PCS,
  output logic                  NextPC,
  output logic                  RegW,
  output logic                  MemW,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [1:0]            FlagW,
  output logic                  Busy,
  output logic                  Undef
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_MULEXEC = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10
  } state_t;

  // Terminal value of the multiply iteration counter.
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_mul_cnt;

  logic [3:0] w_cmd;
  logic       w_s;
  logic       w_is_mul;
  logic       w_is_cmp;
  logic       w_mul_last;
  logic [2:0] w_alu3;
  logic [1:0] w_dp_flagw;
  logic       w_branch;

  assign w_cmd      = Funct[4:1];
  assign w_s        = Funct[0];
  // MUL shares the data-processing opcode space; only Instr[7:4]=1001 with a register operand
  // and cmd[3:1]=000 distinguishes it from AND/EOR.
  assign w_is_mul   = (Op == 2'b00) && !Funct[5] && (Funct[4:2] == 3'b000) && (Instr74 == 4'b1001);
  assign w_is_cmp   = (w_cmd == 4'b1010);
  assign w_mul_last = (r_mul_cnt == MUL_LAST);

  // State register and multiply iteration counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_mul_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_MULEXEC) begin
        r_mul_cnt <= w_mul_last ? 4'd0 : r_mul_cnt + 4'd1;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   w_next = w_is_mul ? S_MULEXEC : (Funct[5] ? S_EXECI : S_EXECR);
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECR,
      S_EXECI:   w_next = w_is_cmp ? S_FETCH : S_ALUWB;
      S_MULEXEC: w_next = w_mul_last ? S_ALUWB : S_MULEXEC;
      default:   w_next = S_FETCH;
    endcase
  end

  // ALU operation and flag-write decode for data-processing commands; unknown commands write nothing.
  always_comb begin
    w_alu3     = 3'b000;
    w_dp_flagw = 2'b00;
    case (w_cmd)
      4'b0100: begin w_alu3 = 3'b000; w_dp_flagw = {w_s, w_s};  end
      4'b0010: begin w_alu3 = 3'b001; w_dp_flagw = {w_s, w_s};  end
      4'b0000: begin w_alu3 = 3'b010; w_dp_flagw = {w_s, 1'b0}; end
      4'b1100: begin w_alu3 = 3'b011; w_dp_flagw = {w_s, 1'b0}; end
      4'b0001: begin w_alu3 = 3'b100; w_dp_flagw = {w_s, 1'b0}; end
      4'b1010: begin w_alu3 = 3'b001; w_dp_flagw = 2'b11;       end
      default: begin w_alu3 = 3'b000; w_dp_flagw = 2'b00;       end
    endcase
  end

  // Datapath controls for the current state; anything not set stays 0.
  always_comb begin
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
    FlagW      = 2'b00;
    Busy       = 1'b0;
    Undef      = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Undef     = (Op == 2'b11);
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR,
      S_EXECI: begin
        ALUSrcB         = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl[2:0] = w_alu3;
        FlagW           = w_dp_flagw;
      end
      S_MULEXEC: begin
        ALUControl[2:0] = 3'b101;
        Busy            = 1'b1;
        // Flags are written once the product is complete.
        FlagW           = w_mul_last ? {w_s, 1'b0} : 2'b00;
      end
      S_ALUWB: RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
    PCS = ((Rd == 4'hF) && RegW) || w_branch;
  end

  // Immediate and register-source selects follow the opcode directly.
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: a per-instruction cycle model built from the control rules,
// compared against the DUT every cycle, plus literal expectations pinning the model.
module tb_mc_control_unit;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Instr74;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [1:0] FlagW;
  logic       Busy, Undef;

  always #5 clk = ~clk;

  mc_control_unit #(.MUL_CYCLES(MC), .ALU_CTRL_W(3)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Instr74(Instr74),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .Busy(Busy), .Undef(Undef)
  );

  typedef struct packed {
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc, regsrc;
    logic [2:0] aluctl;
    logic [1:0] flagw;
    logic       busy, undef;
  } out_t;

  out_t act;
  assign act = {PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegSrc, ALUControl, FlagW, Busy, Undef};

  int   n_checks = 0;
  int   n_pass   = 0;
  int   busy_seen, regw_seen;
  out_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic out_t base(input logic [1:0] op);
    out_t o = '0;
    o.immsrc = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    return o;
  endfunction

  // Hand-written FETCH outputs with Op=00.
  function automatic out_t fetch_lit();
    out_t o = '0;
    o.irwrite = 1'b1; o.nextpc = 1'b1;
    o.alusrca = 2'b10; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    return o;
  endfunction

  // Expected output vector for every cycle of one instruction, FETCH first.
  function automatic void build(input logic [1:0] op, input logic [5:0] funct,
                                input logic [3:0] rd, input logic [3:0] i74);
    out_t       o;
    logic [3:0] cmd = funct[4:1];
    logic       s   = funct[0];
    logic       mul = (op == 2'b00) && !funct[5] && (cmd[3:1] == 3'b000) && (i74 == 4'b1001);
    logic [2:0] a;
    logic [1:0] f;
    logic       wb  = 1'b0;
    exp_q.delete();
    o = base(op); o.irwrite = 1; o.nextpc = 1; o.alusrca = 2; o.alusrcb = 2; o.resultsrc = 2;
    exp_q.push_back(o);
    o = base(op); o.alusrca = 2; o.alusrcb = 2; o.resultsrc = 2; o.undef = (op == 2'b11);
    exp_q.push_back(o);
    case (op)
      2'b10: begin
        o = base(op); o.alusrca = 2; o.alusrcb = 1; o.resultsrc = 2; o.pcs = 1;
        exp_q.push_back(o);
      end
      2'b01: begin
        o = base(op); o.alusrcb = 1; exp_q.push_back(o);
        if (funct[0]) begin
          o = base(op); o.adrsrc = 1; exp_q.push_back(o);
          o = base(op); o.resultsrc = 1; o.regw = 1; o.pcs = (rd == 4'hF); exp_q.push_back(o);
        end else begin
          o = base(op); o.adrsrc = 1; o.memw = 1; exp_q.push_back(o);
        end
      end
      2'b00: begin
        if (mul) begin
          for (int k = 0; k < MC; k++) begin
            o = base(op); o.aluctl = 3'b101; o.busy = 1;
            o.flagw = (k == MC - 1) ? {s, 1'b0} : 2'b00;
            exp_q.push_back(o);
          end
          wb = 1'b1;
        end else begin
          case (cmd)
            4'b0100: begin a = 0; f = {s, s};    end
            4'b0010: begin a = 1; f = {s, s};    end
            4'b0000: begin a = 2; f = {s, 1'b0}; end
            4'b1100: begin a = 3; f = {s, 1'b0}; end
            4'b0001: begin a = 4; f = {s, 1'b0}; end
            4'b1010: begin a = 1; f = 2'b11;     end
            default: begin a = 0; f = 2'b00;     end
          endcase
          o = base(op); o.alusrcb = funct[5] ? 2'b01 : 2'b00; o.aluctl = a; o.flagw = f;
          exp_q.push_back(o);
          wb = (cmd != 4'b1010);
        end
        if (wb) begin
          o = base(op); o.regw = 1; o.pcs = (rd == 4'hF); exp_q.push_back(o);
        end
      end
      default: ;
    endcase
  endfunction

  // Runs one instruction starting in its FETCH cycle (just after a rising edge); compares
  // every cycle on the falling edge. stop_after>0 checks only that many cycles and stays put.
  task automatic run(input string nm, input logic [1:0] op, input logic [5:0] funct,
                     input logic [3:0] rd, input logic [3:0] i74, input int stop_after);
    int n;
    Op = op; Funct = funct; Rd = rd; Instr74 = i74;
    build(op, funct, rd, i74);
    n = (stop_after > 0) ? stop_after : exp_q.size();
    busy_seen = 0;
    regw_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      busy_seen += int'(Busy);
      regw_seen += int'(RegW);
      check($sformatf("%s cyc%0d", nm, i + 1), 32'(act), 32'(exp_q[i]));
      if (i < n - 1 || stop_after == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; Instr74 = 4'd0;

    // Literal expectations that pin the model.
    build(2'b00, 6'b001000, 4'd1, 4'd0);
    check("model ADD len", exp_q.size(), 4);
    check("model ADD aluctl", 32'(exp_q[2].aluctl), 32'd0);
    check("model ADD regw c4", 32'(exp_q[3].regw), 32'd1);
    build(2'b00, 6'b000101, 4'd15, 4'd0);
    check("model SUBS flagw", 32'(exp_q[2].flagw), 32'h3);
    check("model SUBS pcs c4", 32'(exp_q[3].pcs), 32'd1);
    build(2'b00, 6'b110101, 4'd0, 4'd0);
    check("model CMP len", exp_q.size(), 3);
    check("model CMP alu/flag", 32'({exp_q[2].aluctl, exp_q[2].flagw}), 32'b00111);
    build(2'b00, 6'b000001, 4'd2, 4'b1001);
    check("model MULS len", exp_q.size(), 7);
    check("model MULS flagw c6", 32'(exp_q[5].flagw), 32'h2);
    check("model MULS flagw c5", 32'(exp_q[4].flagw), 32'h0);
    build(2'b01, 6'b011001, 4'd3, 4'd0);
    check("model LDR len", exp_q.size(), 5);
    build(2'b01, 6'b011000, 4'd3, 4'd0);
    check("model STR len", exp_q.size(), 4);
    check("model STR memw c4", 32'(exp_q[3].memw), 32'd1);
    build(2'b10, 6'b100000, 4'd0, 4'd0);
    check("model B len", exp_q.size(), 3);
    check("model B pcs c3", 32'(exp_q[2].pcs), 32'd1);
    build(2'b11, 6'b000000, 4'd0, 4'd0);
    check("model UNDEF len", exp_q.size(), 2);

    // Reset state.
    @(negedge clk);
    check("reset state", 32'(act), 32'(fetch_lit()));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("after reset", 32'(act), 32'(fetch_lit()));

    run("ADD R1",    2'b00, 6'b001000, 4'd1,  4'b0000, 0);
    check("ADD regw cycles", regw_seen, 1);
    run("SUBS R15",  2'b00, 6'b000101, 4'd15, 4'b0000, 0);
    run("CMP imm",   2'b00, 6'b110101, 4'd0,  4'b0000, 0);
    check("CMP regw cycles", regw_seen, 0);
    run("MULS",      2'b00, 6'b000001, 4'd2,  4'b1001, 0);
    check("MULS busy cycles", busy_seen, 4);
    check("MULS regw cycles", regw_seen, 1);
    run("LDR",       2'b01, 6'b011001, 4'd3,  4'b0000, 0);
    run("STR",       2'b01, 6'b011000, 4'd3,  4'b0000, 0);
    run("B",         2'b10, 6'b100000, 4'd0,  4'b0000, 0);
    run("UNDEF",     2'b11, 6'b000000, 4'd0,  4'b0000, 0);
    run("ORR imm",   2'b00, 6'b111000, 4'd4,  4'b0000, 0);
    run("EORS",      2'b00, 6'b000011, 4'd5,  4'b0000, 0);
    run("MOVS unk",  2'b00, 6'b011011, 4'd6,  4'b0000, 0);
    run("AND imm",   2'b00, 6'b100000, 4'd7,  4'b1001, 0);
    run("LDR PC",    2'b01, 6'b011001, 4'd15, 4'b0000, 0);
    run("MUL",       2'b00, 6'b000000, 4'd8,  4'b1001, 0);

    // Reset in the second MULEXEC cycle, then a full multiply.
    run("MUL abort", 2'b00, 6'b000000, 4'd5,  4'b1001, 4);
    #2 reset = 1'b1;
    #1 check("reset in MULEXEC", 32'(act), 32'(fetch_lit()));
    @(posedge clk);
    #1 reset = 1'b0;
    run("MUL after reset", 2'b00, 6'b000001, 4'd9, 4'b1001, 0);
    check("MUL after reset busy", busy_seen, 4);
    run("ADD after MUL", 2'b00, 6'b001000, 4'd1, 4'b0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle control unit for the ARM-subset core. It combines the main FSM, ALU decoder, PC logic and instruction decoder into one block, and adds three things: an iterative multiply state with a parametrised cycle count, compare (CMP) without register writeback, and undefined-opcode detection. It sits between the instruction register and the datapath, and drives every datapath mux and write enable.

## Interface
Parameters:
- MUL_CYCLES, 4, number of cycles spent in MULEXEC; legal range 1–15.
- ALU_CTRL_W, 3, width of ALUControl; must be ≥3.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state=FETCH, mul_cnt=0.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: I, cmd[3:0], S (or L for memory).
- Rd  in  4  Instr[15:12].
- Instr74  in  4  Instr[7:4]; 4'b1001 marks multiply.
- PCS, NextPC, RegW, MemW, IRWrite, AdrSrc  out  1  datapath enables/selects.
- ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc  out  2  datapath mux selects.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- FlagW  out  2  flag-write enables: [1]=NZ, [0]=CV.
- Busy  out  1  high while in MULEXEC.
- Undef  out  1  high in DECODE when Op=11.

## Operation
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULEXEC, ALUWB, BRANCH.
- Outputs not listed for a state are 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=10, ALUSrcB=10, ResultSrc=10. Next state: DECODE.
- DECODE: ALUSrcA=10, ALUSrcB=10, ResultSrc=10. Next state:
  - MUL (Op=00, Funct[5]=0, Funct[4:2]=000, Instr74=1001) → MULEXEC.
  - Op=00 with Funct[5]=1 → EXECI; otherwise Op=00 → EXECR.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH, with Undef=1.
- MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegW=1 → FETCH.
- MEMWR: AdrSrc=1, MemW=1 → FETCH.
- EXECR / EXECI:
  - ALUSrcA=00; ALUSrcB=00 in EXECR, 01 in EXECI; ALU decode active.
  - Next state: CMP (cmd=1010) → FETCH; else → ALUWB.
- MULEXEC:
  - ALUSrcA=00, ALUSrcB=00, ALUControl=101, Busy=1.
  - mul_cnt increments each cycle; when mul_cnt=MUL_CYCLES-1, clear mul_cnt and go to ALUWB.
- ALUWB: ResultSrc=00, RegW=1 → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, internal Branch=1 → FETCH.
- ALU decode, active in EXECR/EXECI only:
  - cmd 0100→000 (ADD), 0010→001 (SUB), 0000→010 (AND), 1100→011 (ORR), 0001→100 (EOR), 1010→001 (CMP).
  - Any other cmd → ALUControl=0 and FlagW=00, never X.
  - Upper ALUControl bits above bit 2 are 0.
- FlagW:
  - EXECR/EXECI: CMP → 11. Otherwise FlagW[1]=S and FlagW[0]=S&(ADD|SUB).
  - MULEXEC: FlagW={S,0}, asserted on the final MULEXEC cycle only.
  - All other states: 00.
- ALUControl outside EXECR/EXECI/MULEXEC is 000 (PC+4 / address add).
- PCS=((Rd==4'hF)&RegW)|Branch.
- ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).

## Timing
- State register and mul_cnt update on the rising edge of clk.
- Outputs are combinational from state, plus Funct/Rd/Op where stated above.
- After reset deassertion, outputs equal the FETCH values: IRWrite=1, NextPC=1, ALUSrcA=10, ALUSrcB=10, ResultSrc=10, all write enables 0, Busy=0, Undef=0.
- Cycles per instruction:
  - Data-processing: 4.
  - CMP: 3.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - Undefined: 2.
  - MUL: 3+MUL_CYCLES.
- Reset asserted mid-MULEXEC clears mul_cnt asynchronously; the next instruction starts from FETCH with no RegW pulse.
- With MUL_CYCLES=1, MULEXEC lasts exactly one cycle.
- Funct and Op must stay stable from DECODE through writeback; the IR guarantees this because IRWrite is high only in FETCH.

## Test plan
- Reset, then ADD R1 (Op=00, Funct=001000, Rd=1): states FETCH→DECODE→EXECR→ALUWB; ALUControl=000 in EXECR; RegW=1 only in cycle 4; PCS=0.
- SUBS with Rd=15 (Funct=000101): FlagW=11 in EXECR; in ALUWB RegW=1 and PCS=1.
- CMP immediate (Funct=110101): ALUControl=001, FlagW=11 in EXECI; returns to FETCH in cycle 4 with RegW never asserted.
- MULS with MUL_CYCLES=4 (Funct=000001, Instr74=1001):
  - Busy=1 for exactly 4 cycles, ALUControl=101 throughout.
  - FlagW=10 only on the 4th MULEXEC cycle.
  - ALUWB follows; total 7 cycles.
- LDR (Op=01, Funct[0]=1) takes 5 cycles with MemW=0. STR takes 4 cycles with MemW=1 in cycle 4. B takes 3 cycles with PCS=1 in cycle 3.
- Op=11: Undef=1 in cycle 2, then FETCH. Reset pulsed in MULEXEC cycle 2: state=FETCH immediately, next MUL again takes the full MUL_CYCLES.
